// File: rtl/sevseg_hex_display_ctrl.sv
// Avalon-MM slave that turns hex nibbles into seven-segment patterns, with per-digit
// blanking and per-digit blinking paced by a programmable half-period prescaler.
module sevseg_hex_display_ctrl #(
  parameter int          NUM_DIGITS = 4,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter logic [31:0] RESET_DATA = 32'h0,
  parameter logic [31:0] DIV_RESET  = 32'd25_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [NUM_DIGITS*7-1:0]   seg_out,
  output logic                      blink_phase
);

  localparam int DW = NUM_DIGITS * 4;
  localparam int SW = NUM_DIGITS * 7;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
    endcase
    return p;
  endfunction

  // Blank wins over blink; a hidden digit has every segment dark in either polarity.
  function automatic logic [SW-1:0] render(input logic [DW-1:0]         data,
                                           input logic [NUM_DIGITS-1:0] blank,
                                           input logic [NUM_DIGITS-1:0] blink,
                                           input logic                  phase);
    logic [SW-1:0] r;
    logic [6:0]    pat;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (blank[i] | (blink[i] & phase)) pat = 7'h00;
      else                               pat = hex7(data[4*i +: 4]);
      r[7*i +: 7] = ACTIVE_LOW ? ~pat : pat;
    end
    return r;
  endfunction

  logic [DW-1:0]         data_q,  data_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [NUM_DIGITS-1:0] blink_q, blink_d;
  logic [31:0]           div_q,   div_d;
  logic [31:0]           cnt_q,   cnt_d;
  logic                  phase_q, phase_d;
  logic [SW-1:0]         seg_q,   seg_d;

  logic wr_en, wr_data, wr_ctrl, wr_div;

  assign wr_en   = chipselect & ~write_n;
  assign wr_data = wr_en && (address == 2'd0);
  assign wr_ctrl = wr_en && (address == 2'd1);
  assign wr_div  = wr_en && (address == 2'd2);

  always_comb begin
    data_d  = data_q;
    blank_d = blank_q;
    blink_d = blink_q;
    div_d   = div_q;
    if (wr_data) data_d = writedata[DW-1:0];
    if (wr_ctrl) begin
      blank_d = writedata[NUM_DIGITS-1:0];
      blink_d = writedata[8 +: NUM_DIGITS];
    end
    if (wr_div) div_d = writedata;
  end

  // A BLINK_DIV write restarts the half-period, so a lowered divisor never leaves the
  // counter past its terminal count.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr_div || div_q == 32'd0) begin
      cnt_d   = 32'd0;
      phase_d = 1'b0;
    end else if (cnt_q == div_q - 32'd1) begin
      cnt_d   = 32'd0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 32'd1;
    end
  end

  assign seg_d = render(data_q, blank_q, blink_q, phase_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= RESET_DATA[DW-1:0];
      blank_q <= '0;
      blink_q <= '0;
      div_q   <= DIV_RESET;
      cnt_q   <= 32'd0;
      phase_q <= 1'b0;
      seg_q   <= render(RESET_DATA[DW-1:0], '0, '0, 1'b0);
    end else begin
      data_q  <= data_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: readdata[DW-1:0] = data_q;
      2'd1: begin
        readdata[NUM_DIGITS-1:0]  = blank_q;
        readdata[8 +: NUM_DIGITS] = blink_q;
      end
      2'd2: readdata = div_q;
      default: readdata[0] = phase_q;
    endcase
  end

  assign seg_out     = seg_q;
  assign blink_phase = phase_q;

endmodule
